// File: rtl/tdo_capture_pkg.sv
// Shared executor definitions: TAP state codes, byte width and capture FSM states.
// The register file imports the same package.
package tdo_capture_pkg;

    localparam int unsigned ByteW = 8;

    typedef enum logic [3:0] {
        TapTlr   = 4'h0,
        TapRti   = 4'h1,
        TapSeldr = 4'h2,
        TapSelir = 4'h3,
        TapCapdr = 4'h4,
        TapCapir = 4'h5,
        TapShdr  = 4'h6,
        TapShir  = 4'h7,
        TapEx1dr = 4'h8,
        TapEx1ir = 4'h9,
        TapPadr  = 4'ha,
        TapPair  = 4'hb,
        TapEx2dr = 4'hc,
        TapEx2ir = 4'hd,
        TapUpdr  = 4'he,
        TapUpir  = 4'hf
    } tap_state_e;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFlush
    } cap_state_e;

endpackage

// File: rtl/tdo_capture_if.sv
// Register-file side of the TDO capture stage.
// master = register file, slave = capture.
interface tdo_capture_if;
    import tdo_capture_pkg::*;

    logic [ByteW-1:0] exp;
    logic [ByteW-1:0] mask;
    logic             byte_ack;
    logic             clear_dm;
    logic [ByteW-1:0] meas;
    logic [ByteW-1:0] fail;
    logic [ByteW-1:0] dm_fail;
    logic             fail_flag;
    logic             byte_req;
    logic             overrun;
    logic [2:0]       bit_cnt;

    modport master (
        output exp, mask, byte_ack, clear_dm,
        input  meas, fail, dm_fail, fail_flag, byte_req, overrun, bit_cnt
    );

    modport slave (
        input  exp, mask, byte_ack, clear_dm,
        output meas, fail, dm_fail, fail_flag, byte_req, overrun, bit_cnt
    );

endinterface

// File: rtl/tdo_capture_sync.sv
// Multi-flop synchroniser for the asynchronous TDO return line.
module tdo_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/tdo_capture.sv
// Samples synchronised TDO during Shift-DR/IR, assembles LSB-first bytes and
// compares them against the expected/mask bytes from the register file.
module tdo_capture
    import tdo_capture_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [3:0]  SHIR        = TapShir,
    parameter logic [3:0]  SHDR        = TapShdr
) (
    input  logic          clk_cpu,
    input  logic          reset,
    input  logic          tdo_in,
    input  logic          tck_sample_en,
    input  logic [3:0]    state,
    tdo_capture_if.slave  bus
);

    cap_state_e       fsm_q, fsm_d;
    logic [ByteW-1:0] sh_q, sh_d, fv_q, fv_d, exp_q, exp_d, mask_q, mask_d;
    logic [ByteW-1:0] meas_q, meas_d, fail_q, fail_d, dm_q, dm_d;
    logic             flag_q, flag_d, req_q, req_d, ovr_q, ovr_d;
    logic [2:0]       cnt_q, cnt_d;

    logic             tdo_s, in_shift, sample, mis, commit;
    logic [ByteW-1:0] cur_exp, cur_mask, sh_next, fv_next, low_mask;
    logic [ByteW-1:0] commit_meas, commit_fail;
    logic [3:0]       pad;

    tdo_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk_cpu),
        .reset (reset),
        .d     (tdo_in),
        .q     (tdo_s)
    );

    assign in_shift = (state == SHDR) || (state == SHIR);
    // Once in StShift a strobe is honoured even if the TAP state moves the same cycle.
    assign sample   = tck_sample_en && ((fsm_q == StShift) || ((fsm_q == StIdle) && in_shift));

    always_comb begin
        fsm_d       = fsm_q;
        sh_d        = sh_q;
        fv_d        = fv_q;
        exp_d       = exp_q;
        mask_d      = mask_q;
        meas_d      = meas_q;
        fail_d      = fail_q;
        flag_d      = flag_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        commit      = 1'b0;
        commit_meas = '0;
        commit_fail = '0;

        // First bit of a byte compares against the exp/mask being latched now.
        cur_exp  = (cnt_q == 3'd0) ? bus.exp  : exp_q;
        cur_mask = (cnt_q == 3'd0) ? bus.mask : mask_q;
        mis      = (tdo_s ^ cur_exp[cnt_q]) & cur_mask[cnt_q];
        sh_next  = {tdo_s, sh_q[ByteW-1:1]};
        fv_next  = fv_q;
        fv_next[cnt_q] = mis;
        pad      = 4'd8 - {1'b0, cnt_q};
        low_mask = 8'hff >> pad;

        dm_d  = bus.clear_dm ? '0 : dm_q;
        ovr_d = bus.clear_dm ? 1'b0 : ovr_q;

        unique case (fsm_q)
            StIdle: begin
                if (in_shift) fsm_d = StShift;
            end
            StShift: begin
                if (!tck_sample_en && !in_shift) begin
                    flag_d = 1'b0;
                    fsm_d  = (cnt_q != 3'd0) ? StFlush : StIdle;
                end
            end
            StFlush: begin
                commit      = 1'b1;
                commit_meas = sh_q >> pad;
                commit_fail = fv_q & low_mask;
                cnt_d       = 3'd0;
                flag_d      = 1'b0;
                fsm_d       = StIdle;
            end
            default: fsm_d = StIdle;
        endcase

        if (sample) begin
            sh_d   = sh_next;
            fv_d   = fv_next;
            flag_d = mis;
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == 3'd0) begin
                exp_d  = bus.exp;
                mask_d = bus.mask;
                if (req_q) ovr_d = 1'b1;
            end
            if (cnt_q == 3'd7) begin
                commit      = 1'b1;
                commit_meas = sh_next;
                commit_fail = fv_next;
            end
        end

        if (bus.byte_ack) req_d = 1'b0;
        if (commit) begin
            meas_d = commit_meas;
            fail_d = commit_fail;
            dm_d   = dm_d | commit_fail;
            req_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            fsm_q  <= StIdle;
            sh_q   <= '0;
            fv_q   <= '0;
            exp_q  <= '0;
            mask_q <= '0;
            meas_q <= '0;
            fail_q <= '0;
            dm_q   <= '0;
            flag_q <= 1'b0;
            req_q  <= 1'b0;
            ovr_q  <= 1'b0;
            cnt_q  <= 3'd0;
        end else begin
            fsm_q  <= fsm_d;
            sh_q   <= sh_d;
            fv_q   <= fv_d;
            exp_q  <= exp_d;
            mask_q <= mask_d;
            meas_q <= meas_d;
            fail_q <= fail_d;
            dm_q   <= dm_d;
            flag_q <= flag_d;
            req_q  <= req_d;
            ovr_q  <= ovr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.meas      = meas_q;
    assign bus.fail      = fail_q;
    assign bus.dm_fail   = dm_q;
    assign bus.fail_flag = flag_q;
    assign bus.byte_req  = req_q;
    assign bus.overrun   = ovr_q;
    assign bus.bit_cnt   = cnt_q;

endmodule

// File: tb/tb_tdo_capture.sv
// Bench for tdo_capture: directed scenarios plus randomized shift sessions
// checked against a bit-list reference model.
module tb_tdo_capture;
    import tdo_capture_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tdo_in = 1'b0;
    logic       tck    = 1'b0;
    logic [3:0] st     = TapRti;

    always #5 clk = ~clk;

    tdo_capture_if bus ();

    tdo_capture #(
        .SYNC_STAGES(2),
        .SHIR       (TapShir),
        .SHDR       (TapShdr)
    ) dut (
        .clk_cpu       (clk),
        .reset         (rst_n),
        .tdo_in        (tdo_in),
        .tck_sample_en (tck),
        .state         (st),
        .bus           (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: captured bits kept as a list, bytes built arithmetically.
    logic [7:0] m_meas, m_fail, m_dm, m_exp, m_mask;
    logic       m_flag, m_req, m_ovr, m_active;
    logic       b_q[$];

    function automatic void model_reset();
        m_meas = 0; m_fail = 0; m_dm = 0; m_exp = 0; m_mask = 0;
        m_flag = 0; m_req = 0; m_ovr = 0; m_active = 0;
        b_q.delete();
    endfunction

    function automatic void model_commit();
        logic [7:0] mv = 0;
        logic [7:0] fv = 0;
        foreach (b_q[i]) begin
            mv = mv + (8'(b_q[i]) << i);
            if ((b_q[i] != m_exp[i]) && m_mask[i]) fv = fv + (8'd1 << i);
        end
        m_meas = mv;
        m_fail = fv;
        m_dm   = m_dm | fv;
        m_req  = 1'b1;
        b_q.delete();
    endfunction

    function automatic void model_sample(input logic b, input logic clr, input logic ack);
        logic was_req = m_req;
        int   k       = b_q.size();
        if (clr) begin m_dm = 0; m_ovr = 0; end
        if (ack) m_req = 0;
        if (k == 0) begin
            m_exp  = bus.exp;
            m_mask = bus.mask;
            if (was_req) m_ovr = 1'b1;
        end
        m_flag = (b != m_exp[k]) && m_mask[k];
        b_q.push_back(b);
        if (b_q.size() == 8) model_commit();
    endfunction

    function automatic logic [29:0] exp_vec();
        return {m_meas, m_fail, m_dm, m_flag, m_req, m_ovr, 3'(b_q.size())};
    endfunction

    function automatic logic [29:0] dut_vec();
        return {bus.meas, bus.fail, bus.dm_fail, bus.fail_flag, bus.byte_req, bus.overrun,
                bus.bit_cnt};
    endfunction

    task automatic shift_bit(input logic b, input logic clr, input logic ack,
                             input logic [3:0] st_strobe);
        tdo_in = b;
        repeat (3) begin @(posedge clk); #1; end
        tck = 1'b1; bus.clear_dm = clr; bus.byte_ack = ack; st = st_strobe;
        @(posedge clk); #1;
        tck = 1'b0; bus.clear_dm = 1'b0; bus.byte_ack = 1'b0;
        if (m_active) begin
            model_sample(b, clr, ack);
        end else begin
            if (clr) begin m_dm = 0; m_ovr = 0; end
            if (ack) m_req = 0;
        end
    endtask

    task automatic enter_shift(input logic [3:0] s);
        st = s;
        @(posedge clk); #1;
        m_active = 1'b1;
    endtask

    task automatic leave_shift(input logic [3:0] s);
        st = s;
        repeat (2) begin @(posedge clk); #1; end
        if (m_active) begin
            m_flag = 1'b0;
            if (b_q.size() != 0) model_commit();
        end
        m_active = 1'b0;
    endtask

    task automatic do_ack();
        bus.byte_ack = 1'b1; @(posedge clk); #1; bus.byte_ack = 1'b0;
        m_req = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear_dm = 1'b1; @(posedge clk); #1; bus.clear_dm = 1'b0;
        m_dm = 0; m_ovr = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; st = TapRti; model_reset();
        repeat (2) begin @(posedge clk); #1; end
        vectors++;
        if (dut_vec() !== 30'h0) begin
            miscompares++; $display("FAIL reset_state: got %h want %h", dut_vec(), 30'h0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (dut_vec() !== exp_vec()) begin
            miscompares++; $display("FAIL reset_release: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_full_match();
        logic [7:0] pat = 8'ha5;
        bus.exp = 8'ha5; bus.mask = 8'hff;
        enter_shift(TapShdr);
        for (int i = 0; i < 8; i++) begin
            shift_bit(pat[i], 1'b0, 1'b0, TapShdr);
            vectors++;
            if (dut_vec() !== exp_vec() || bus.fail_flag !== 1'b0) begin
                miscompares++;
                $display("FAIL full_match bit%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (bus.meas !== 8'ha5 || bus.fail !== 8'h00 || bus.byte_req !== 1'b1) begin
            miscompares++;
            $display("FAIL full_match_byte: got meas %h fail %h req %b want a5 00 1",
                     bus.meas, bus.fail, bus.byte_req);
        end
        do_ack();
        vectors++;
        if (bus.byte_req !== 1'b0) begin
            miscompares++; $display("FAIL ack_clears_req: got %b want 0", bus.byte_req);
        end
        leave_shift(TapEx1dr);
    endtask

    task automatic test_masked_mismatch();
        logic [7:0] pat = 8'hf3;
        bus.exp = 8'h00; bus.mask = 8'h0f;
        enter_shift(TapShdr);
        for (int i = 0; i < 8; i++) begin
            shift_bit(pat[i], 1'b0, 1'b0, TapShdr);
            vectors++;
            if (dut_vec() !== exp_vec() || bus.fail_flag !== (i < 2)) begin
                miscompares++;
                $display("FAIL masked_bit%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (bus.fail !== 8'h03 || bus.dm_fail !== 8'h03 || bus.meas !== 8'hf3) begin
            miscompares++;
            $display("FAIL masked_byte: got fail %h dm %h meas %h want 03 03 f3",
                     bus.fail, bus.dm_fail, bus.meas);
        end
        do_ack();
        leave_shift(TapEx1dr);
    endtask

    task automatic test_partial_flush();
        logic [2:0] pat = 3'b011;
        bus.exp = 8'hff; bus.mask = 8'hff;
        enter_shift(TapShir);
        for (int i = 0; i < 3; i++) shift_bit(pat[i], 1'b0, 1'b0, TapShir);
        vectors++;
        if (dut_vec() !== exp_vec() || bus.bit_cnt !== 3'd3) begin
            miscompares++; $display("FAIL partial_pre: got %h want %h", dut_vec(), exp_vec());
        end
        leave_shift(TapEx1ir);
        vectors++;
        if (bus.meas !== 8'h03 || bus.fail !== 8'h04 || bus.bit_cnt !== 3'd0 ||
            bus.byte_req !== 1'b1 || bus.fail_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL partial_flush: got meas %h fail %h cnt %0d req %b want 03 04 0 1",
                     bus.meas, bus.fail, bus.bit_cnt, bus.byte_req);
        end
        do_ack();
        vectors++;
        if (dut_vec() !== exp_vec()) begin
            miscompares++; $display("FAIL partial_post: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_overrun();
        bus.exp = 8'h00; bus.mask = 8'h00;
        enter_shift(TapShdr);
        for (int i = 0; i < 8; i++) shift_bit(1'b1, 1'b0, 1'b0, TapShdr);
        shift_bit(1'b0, 1'b0, 1'b0, TapShdr);
        vectors++;
        if (bus.overrun !== 1'b1 || dut_vec() !== exp_vec()) begin
            miscompares++; $display("FAIL overrun_set: got %h want %h", dut_vec(), exp_vec());
        end
        shift_bit(1'b1, 1'b0, 1'b0, TapShdr);
        vectors++;
        if (bus.overrun !== 1'b1) begin
            miscompares++; $display("FAIL overrun_sticky: got %b want 1", bus.overrun);
        end
        do_clear();
        vectors++;
        if (bus.overrun !== 1'b0 || bus.dm_fail !== 8'h00) begin
            miscompares++;
            $display("FAIL overrun_clear: got ovr %b dm %h want 0 00", bus.overrun, bus.dm_fail);
        end
        leave_shift(TapEx1dr);
        do_ack();
        do_clear();
    endtask

    task automatic test_sticky_clear();
        logic [7:0] pats[3] = '{8'h10, 8'h01, 8'h80};
        logic [7:0] want_dm[3] = '{8'h10, 8'h11, 8'h80};
        bus.exp = 8'h00; bus.mask = 8'hff;
        enter_shift(TapShdr);
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++) begin
                shift_bit(pats[b][i], (b == 2) && (i == 7), 1'b0, TapShdr);
            end
            vectors++;
            if (bus.dm_fail !== want_dm[b] || dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL sticky_byte%0d: got dm %h want %h (vec %h/%h)",
                         b, bus.dm_fail, want_dm[b], dut_vec(), exp_vec());
            end
            do_ack();
        end
        leave_shift(TapEx1dr);
    endtask

    task automatic test_async_reset();
        logic [7:0] pat = 8'h5c;
        bus.exp = 8'hff; bus.mask = 8'hff;
        enter_shift(TapShdr);
        for (int i = 0; i < 5; i++) shift_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0, TapShdr);
        @(negedge clk); #2;
        rst_n = 1'b0; st = TapRti;
        #1;
        vectors++;
        if (dut_vec() !== 30'h0) begin
            miscompares++; $display("FAIL async_reset: got %h want %h", dut_vec(), 30'h0);
        end
        model_reset();
        @(posedge clk); #3; rst_n = 1'b1;
        @(posedge clk); #1;
        enter_shift(TapShdr);
        vectors++;
        if (bus.bit_cnt !== 3'd0 || dut_vec() !== exp_vec()) begin
            miscompares++; $display("FAIL reset_reentry: got %h want %h", dut_vec(), exp_vec());
        end
        for (int i = 0; i < 8; i++) shift_bit(pat[i], 1'b0, 1'b0, TapShdr);
        vectors++;
        if (bus.meas !== 8'h5c || dut_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_fresh_byte: got meas %h want 5c (vec %h/%h)",
                     bus.meas, dut_vec(), exp_vec());
        end
        do_ack();
        leave_shift(TapEx1dr);
    endtask

    task automatic test_random();
        for (int s = 0; s < 40; s++) begin
            logic [3:0] sst;
            logic [3:0] xst;
            int         nb;
            logic       last_exit;
            sst = ($urandom_range(0, 1) != 0) ? TapShdr : TapShir;
            xst = ($urandom_range(0, 1) != 0) ? TapEx1dr : TapEx1ir;
            nb  = $urandom_range(1, 12);
            if ($urandom_range(0, 3) == 0) begin
                shift_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0, TapRti);
                vectors++;
                if (dut_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL idle_strobe s%0d: got %h want %h", s, dut_vec(), exp_vec());
                end
            end
            enter_shift(sst);
            for (int i = 0; i < nb; i++) begin
                bus.exp  = 8'($urandom);
                bus.mask = 8'($urandom);
                last_exit = (i == nb - 1) && ($urandom_range(0, 3) == 0);
                shift_bit(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                          $urandom_range(0, 2) == 0, last_exit ? xst : sst);
                vectors++;
                if (dut_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL rand s%0d b%0d: got %h want %h", s, i, dut_vec(), exp_vec());
                end
            end
            leave_shift(xst);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL rand_exit s%0d: got %h want %h", s, dut_vec(), exp_vec());
            end
            if ($urandom_range(0, 1) != 0) do_ack();
        end
    endtask

    initial begin
        bus.exp = 8'h00; bus.mask = 8'h00; bus.byte_ack = 1'b0; bus.clear_dm = 1'b0;
        test_reset();
        test_full_match();
        test_masked_mismatch();
        test_partial_flush();
        test_overrun();
        test_sticky_clear();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
